// File: rtl/div_unit.sv
// div_unit: sequential restoring divider (DIV/DIVU) producing quotient in Lo and remainder in Hi; optional abort via DIV_ABORT_EN
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] Hi,
    output logic             DivZero
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] FIX     = 2'd2;
    localparam logic [1:0] DONE_ST = 2'd3;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs, a_raw, a_mag, b_mag, rem_sub;
    logic [WIDTH:0]   rem_sh;
    logic             neg_q, neg_r, zero, ge, accept, kill;
    // operand magnitudes, one restoring step, and handshake decode
    always_comb begin
        a_mag   = (Sign && A[WIDTH-1]) ? -A : A;
        b_mag   = (Sign && B[WIDTH-1]) ? -B : B;
        rem_sh  = {rem, quo[WIDTH-1]};
        ge      = rem_sh >= {1'b0, dvs};
        rem_sub = rem_sh[WIDTH-1:0] - dvs;
        accept  = start && (state == IDLE || state == DONE_ST);
        Busy    = state == RUN || state == FIX;
        Done    = state == DONE_ST;
`ifdef DIV_ABORT_EN
        kill    = abort && Busy;
`else
        kill    = 1'b0;
`endif
    end
    // control FSM, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            a_raw   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            zero    <= 1'b0;
            Lo      <= '0;
            Hi      <= '0;
            DivZero <= 1'b0;
        end else if (kill) begin
            state <= IDLE;
        end else if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            a_raw <= A;
            neg_q <= Sign && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r <= Sign && A[WIDTH-1];
            zero  <= B == '0;
            state <= (B == '0) ? FIX : RUN;
        end else if (state == RUN) begin
            rem   <= ge ? rem_sub : rem_sh[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], ge};
            cnt   <= cnt + 1'b1;
            state <= (cnt == CNT_W'(WIDTH - 1)) ? FIX : RUN;
        end else if (state == FIX) begin
            Lo      <= zero ? '0 : (neg_q ? -quo : quo);
            Hi      <= zero ? a_raw : (neg_r ? -rem : rem);
            DivZero <= zero;
            state   <= DONE_ST;
        end else if (state == DONE_ST) begin
            state <= IDLE;
        end
    end
endmodule
